// File: rtl/classifier_frame_feeder.sv
// rtl/classifier_frame_feeder.sv - ping-pong frame buffer feeding pixels to the classifier input RAM port
module classifier_frame_feeder #(
    parameter int FRAME_PIXELS = 784,
    parameter int PIXEL_W      = 8,
    parameter int ADDR_W       = 10,
    parameter int RD_DATA_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PIXEL_W-1:0]   pixel_data,
    input  logic                 pixel_valid,
    output logic                 pixel_ready,
    input  logic                 pixel_last,
    input  logic                 classifier_input_valid_write_en,
    input  logic [7:0]           classifier_input_valid_write_data,
    output logic [7:0]           classifier_input_valid_read_data,
    input  logic [ADDR_W-1:0]    classifier_input_address_a,
    output logic [RD_DATA_W-1:0] classifier_input_read_data_a,
    output logic [15:0]          frames_loaded,
    output logic [15:0]          frames_released,
    output logic                 frame_error
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [ADDR_W:0]   NUM_PIX  = (ADDR_W + 1)'(FRAME_PIXELS);

    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [15:0]          loaded_q, loaded_d;
    logic [15:0]          released_q, released_d;
    logic                 error_q, error_d;
    logic [RD_DATA_W-1:0] rd_data_q;

    logic [PIXEL_W-1:0] mem0 [FRAME_PIXELS];
    logic [PIXEL_W-1:0] mem1 [FRAME_PIXELS];

    logic accept, at_last, complete, misalign, release_req, release_ok;
    logic unused_wdata;

    assign unused_wdata = ^classifier_input_valid_write_data[7:1];

    assign pixel_ready = ~full_q[wr_bank_q] & ~reset;
    assign accept      = pixel_valid & pixel_ready;
    assign at_last     = (wr_cnt_q == LAST_IDX);
    assign complete    = accept & at_last & pixel_last;
    assign misalign    = accept & (pixel_last ^ at_last);
    assign release_req = classifier_input_valid_write_en & ~classifier_input_valid_write_data[0];
    assign release_ok  = release_req & full_q[rd_bank_q];

    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_cnt_d   = wr_cnt_q;
        loaded_d   = loaded_q;
        released_d = released_q;
        error_d    = error_q;

        if (complete) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_cnt_d          = '0;
            loaded_d          = loaded_q + 16'd1;
        end else if (misalign) begin
            error_d  = 1'b1;
            wr_cnt_d = '0;
        end else if (accept) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end

        // A completing bank is empty and a released bank is full, so these never collide.
        if (release_ok) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            released_d        = released_q + 16'd1;
        end else if (release_req) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            loaded_q   <= '0;
            released_q <= '0;
            error_q    <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            loaded_q   <= loaded_d;
            released_q <= released_d;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr_bank_q) mem1[wr_cnt_q] <= pixel_data;
            else           mem0[wr_cnt_q] <= pixel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if ({1'b0, classifier_input_address_a} < NUM_PIX) begin
            rd_data_q <= {{(RD_DATA_W - PIXEL_W){1'b0}},
                          (rd_bank_q ? mem1[classifier_input_address_a]
                                     : mem0[classifier_input_address_a])};
        end else begin
            rd_data_q <= '0;
        end
    end

    assign classifier_input_valid_read_data = {7'b0, full_q[rd_bank_q]};
    assign classifier_input_read_data_a     = rd_data_q;
    assign frames_loaded                    = loaded_q;
    assign frames_released                  = released_q;
    assign frame_error                      = error_q;

endmodule
